// File: rtl/bram_ctrl_pkg.sv
// Shared types and default widths for the bram_ctrl arbiter/sequencer.
package bram_ctrl_pkg;

    localparam int AW_DEFAULT = 10;
    localparam int DW_DEFAULT = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter; the grant history advances only on a handshake.
module rr_arb2
    import bram_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_a,
    input  logic req_b,
    input  logic advance,
    output logic gnt_a,
    output logic gnt_b
);

    port_e last_grant_q, last_grant_d;

    always_comb begin
        gnt_a        = 1'b0;
        gnt_b        = 1'b0;
        last_grant_d = last_grant_q;
        if (en) begin
            // On a tie, the port that did not win last time goes first.
            if (req_a && req_b) begin
                gnt_a = (last_grant_q == PORT_B);
                gnt_b = (last_grant_q == PORT_A);
            end else begin
                gnt_a = req_a;
                gnt_b = req_b;
            end
        end
        if (advance) begin
            last_grant_d = gnt_a ? PORT_A : PORT_B;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= PORT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/bram_ctrl.sv
// Shares a single-port BRAM between two requesters and optionally sweep-clears it.
// The clear sequencer is built only when BRAM_CTRL_CLEAR_EN is defined.
module bram_ctrl
    import bram_ctrl_pkg::*;
#(
    parameter int            AW        = AW_DEFAULT,
    parameter int            DW        = DW_DEFAULT,
    parameter logic [DW-1:0] CLR_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    state_e        state_q;
    logic [AW-1:0] clr_addr_q;
    logic          clr_busy_q;
    logic          clr_done_q;
    logic          arb_en;

    logic          gnt_a, gnt_b, handshake;

    logic          cmd_v_q, cmd_v_d;
    port_e         cmd_port_q, cmd_port_d;
    logic          cmd_we_q, cmd_we_d;
    logic [AW-1:0] cmd_addr_q, cmd_addr_d;
    logic [DW-1:0] cmd_wdata_q, cmd_wdata_d;

    logic          a_rvalid_q, a_rvalid_d;
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic          b_rvalid_q, b_rvalid_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;

`ifdef BRAM_CTRL_CLEAR_EN
    state_e        state_d;
    logic [AW-1:0] clr_addr_d;
    logic          clr_busy_d;
    logic          clr_done_d;

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_done_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (clr_start) state_d = DRAIN;
            end
            DRAIN: begin
                state_d    = CLEAR;
                clr_addr_d = '0;
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + AW'(1);
                if (&clr_addr_q) begin
                    state_d    = RUN;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
        clr_busy_d = (state_d != RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            clr_addr_q <= '0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
        end
    end

    // Gating on clr_start keeps a command from slipping in alongside the clear request.
    assign arb_en = (state_q == RUN) && !clr_start;
`else
    logic unused_clr_start;

    assign state_q          = RUN;
    assign clr_addr_q       = '0;
    assign clr_busy_q       = 1'b0;
    assign clr_done_q       = 1'b0;
    assign arb_en           = 1'b1;
    assign unused_clr_start = clr_start;
`endif

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (arb_en),
        .req_a   (a_valid),
        .req_b   (b_valid),
        .advance (handshake),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b)
    );

    assign a_ready   = gnt_a;
    assign b_ready   = gnt_b;
    assign handshake = (a_valid && gnt_a) || (b_valid && gnt_b);

    always_comb begin
        cmd_v_d     = handshake;
        cmd_port_d  = cmd_port_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        if (handshake) begin
            cmd_port_d  = gnt_a ? PORT_A : PORT_B;
            cmd_we_d    = gnt_a ? a_we : b_we;
            cmd_addr_d  = gnt_a ? a_addr : b_addr;
            cmd_wdata_d = gnt_a ? a_wdata : b_wdata;
        end
    end

    // Read data is captured in the cycle the RAM is addressed, so it lands two cycles after acceptance.
    always_comb begin
        a_rvalid_d = cmd_v_q && !cmd_we_q && (cmd_port_q == PORT_A);
        b_rvalid_d = cmd_v_q && !cmd_we_q && (cmd_port_q == PORT_B);
        a_rdata_d  = a_rvalid_d ? mem_dout : a_rdata_q;
        b_rdata_d  = b_rvalid_d ? mem_dout : b_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_v_q     <= 1'b0;
            cmd_port_q  <= PORT_A;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            a_rvalid_q  <= 1'b0;
            a_rdata_q   <= '0;
            b_rvalid_q  <= 1'b0;
            b_rdata_q   <= '0;
        end else begin
            cmd_v_q     <= cmd_v_d;
            cmd_port_q  <= cmd_port_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            a_rvalid_q  <= a_rvalid_d;
            a_rdata_q   <= a_rdata_d;
            b_rvalid_q  <= b_rvalid_d;
            b_rdata_q   <= b_rdata_d;
        end
    end

    assign mem_addr = (state_q == CLEAR) ? clr_addr_q : cmd_addr_q;
    assign mem_din  = (state_q == CLEAR) ? CLR_VALUE : cmd_wdata_q;
    assign mem_we   = (state_q == CLEAR) ? 1'b1 : (cmd_v_q && cmd_we_q);

    assign a_rvalid = a_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rvalid = b_rvalid_q;
    assign b_rdata  = b_rdata_q;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: doc/bram_ctrl.md
# bram_ctrl

Two-port arbiter and sequencer for a single-port 1024x32 block RAM with combinational read and synchronous write. It shares the RAM between requesters A and B using round-robin valid/ready handshakes, and registers each command for one cycle before it reaches the RAM. It returns read data a fixed two cycles after acceptance, and can sweep-clear the whole RAM on request. It sits between two client engines and the RAM instance.

## Interface
Parameters:
- AW, 10, address width; DEPTH = 2**AW
- DW, 32, data width
- CLR_VALUE, 0, word written by the clear sweep (DW bits)

Ports (the "x_" rows exist once for A and once for B):
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- x_valid  in  1  request valid
- x_ready  out  1  request accepted this cycle (combinational, may depend on x_valid)
- x_we  in  1  1 = write, 0 = read
- x_addr  in  AW  word address
- x_wdata  in  DW  write data
- x_rvalid  out  1  one-cycle read-response strobe
- x_rdata  out  DW  read data, held between strobes
- clr_start  in  1  request full-RAM clear
- clr_busy  out  1  clear sequence in progress
- clr_done  out  1  one-cycle pulse when the clear finishes
- mem_we  out  1  RAM write enable
- mem_addr  out  AW  RAM address
- mem_din  out  DW  RAM write data
- mem_dout  in  DW  RAM combinational read data

## Operation
- States: RUN, DRAIN, CLEAR.
  - RUN → DRAIN when clr_start = 1.
  - DRAIN → CLEAR after exactly one cycle.
  - CLEAR → RUN after the write to address DEPTH-1.
- Arbitration happens only in RUN and when clr_start = 0.
  - Only one requester valid: that requester gets ready.
  - Both valid: the requester not granted last time gets ready.
  - last_grant updates only on a handshake; its reset value is B, so A wins the first tie.
- Handshake (valid & ready) loads the command stage: cmd_v, cmd_port, cmd_we, cmd_addr, cmd_wdata. cmd_v clears when there is no handshake.
- RAM drive:
  - In RUN/DRAIN: mem_addr = cmd_addr, mem_din = cmd_wdata, mem_we = cmd_v & cmd_we.
  - In CLEAR: mem_addr = clr_addr, mem_din = CLR_VALUE, mem_we = 1.
- Read response: on a posedge with cmd_v & !cmd_we, the issuing port's x_rdata <= mem_dout and x_rvalid <= 1 for one cycle. Writes produce no response.
- There is no response backpressure; clients must always sink x_rvalid.
- clr_addr is an AW-bit counter. It is zeroed on entering CLEAR, increments once per cycle, and its terminal value is all-ones; no wrap is ever observed.
- clr_start is ignored while clr_busy = 1.
- A command accepted in the same cycle that clr_start is seen is impossible, because ready is gated by clr_start.

## Timing
- Reset values:
  - x_rvalid 0, x_rdata 0
  - clr_busy 0, clr_done 0
  - cmd_v 0, so mem_we 0
  - state RUN, last_grant B
- x_ready can be 1 in the first cycle after reset.
- Request accepted in cycle N: RAM is accessed in cycle N+1; write is committed at the end of N+1; x_rvalid and x_rdata appear in N+2.
- Throughput is one accepted command per cycle in total across both ports.
- Write in cycle N followed by a read of the same address accepted in N+1: the read returns the new data, with no hazard.
- Clear sequence, with clr_start high in cycle N (RUN):
  - Readies are 0 from cycle N onward.
  - N+1: DRAIN; an in-flight command completes and its response still fires in N+2.
  - N+2..N+DEPTH+1: CLEAR writes addresses 0..DEPTH-1.
  - N+DEPTH+2: clr_done = 1, state RUN, grants resume.
- clr_busy = (state != RUN), registered, high N+1..N+DEPTH+1.
- Reset mid-clear: all outputs return to reset values and no clr_done is issued. The RAM stays partially cleared; this is legal.

## Configuration
- Macro BRAM_CTRL_CLEAR_EN.
- Defined: DRAIN/CLEAR states and the clear counter are present, with behaviour as above.
- Undefined:
  - The FSM is fixed in RUN and clr_start is ignored.
  - clr_busy and clr_done are tied 0; the ports remain.
  - Arbitration and latency are unchanged.

## Structure
- Package bram_ctrl_pkg holds:
  - default AW and DW constants
  - the state enum (RUN, DRAIN, CLEAR)
  - the port-id type (PORT_A, PORT_B)
- Sub-module rr_arb2: a two-request round-robin grant with a last_grant register and an advance-on-handshake input.
- The rest is flat in bram_ctrl; the RAM instance stays outside.

## Test plan
- Write then read: A writes 0xDEADBEEF to 0x003 in cycle N, A reads 0x003 in N+1. Expect mem_we high in N+1 and a_rvalid in N+3 with a_rdata = 0xDEADBEEF; b_rvalid stays 0.
- Fair alternation: after reset, A and B both hold valid reading 0x010 and 0x020. Expect grants A, B, A, B…, with rvalid alternating two cycles after each grant.
- Cross-port write/read: B writes 0x5 = 0x12345678 in cycle N, A reads 0x5 in N+1. Expect a_rdata = 0x12345678 in N+3.
- Full clear: fill the RAM with nonzero data, pulse clr_start in cycle N with A valid. Expect:
  - a_ready 0 for N..N+1025
  - clr_busy high for 1025 cycles
  - clr_done pulse in N+1026
  - reads of 0x000, 0x200 and 0x3FF return 0
- Reset mid-clear: assert rst_n = 0 at clear cycle 500. Expect all outputs at reset values, no clr_done, address 0x3FF still holding the old value, and addresses 0..~497 reading 0.
- Macro off, BRAM_CTRL_CLEAR_EN undefined: pulse clr_start while A streams reads. Expect no ready drop, clr_busy = clr_done = 0, and data intact.
